// File: rtl/ifetch_q.sv
// Instruction prefetch queue: a pipelined Wishbone fetcher fills a small word queue,
// and a decoder pops one or two words per instruction into ir/pc.
module ifetch_q #(
    parameter int          DEPTH    = 8,
    parameter int          MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          EXT_BIT  = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic [31:0] bus_adr_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic        bus_stall_i,
    input  logic        pc_set,
    input  logic [31:0] pc_in,
    input  logic        stall_i,
    output logic [63:0] ir,
    output logic [31:0] pc,
    output logic        ir_valid,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int DW = 16;
    localparam int CW = AW + 2;

    // Each entry is {err, data}; the decoder needs the head and the word after it
    // in the same cycle, so the array is read combinationally.
    logic [32:0]   q_mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   occ_reg;
    logic [OW-1:0] out_reg;
    logic [DW-1:0] disc_reg;
    logic [31:0]   adr_reg;
    logic [31:0]   dpc_reg;
    logic [31:0]   pc_reg;
    logic [63:0]   ir_reg;
    logic          valid_reg;
    logic          fault_reg;

    logic          completion;
    logic          take;
    logic          drop;
    logic          issue;
    logic          push;
    logic          pop;
    logic          is_long;
    logic          complete;
    logic [32:0]   head;
    logic [32:0]   second;
    logic [AW:0]   pop_words;
    logic [CW-1:0] out_ext;
    logic [CW-1:0] occ_ext;

    assign out_ext   = CW'(out_reg);
    assign occ_ext   = CW'(occ_reg);

    // Words still in flight are counted against free queue space, so a push
    // always has a slot waiting for it.
    assign bus_stb_o = !rst_i && !pc_set && (out_ext < CW'(MAX_OUT))
                       && ((out_ext + occ_ext) < CW'(DEPTH));
    assign bus_cyc_o = !rst_i && (bus_stb_o || out_reg != '0 || disc_reg != '0);
    assign bus_adr_o = adr_reg;

    assign completion = bus_ack_i || bus_err_i;
    assign drop       = completion && disc_reg != '0;
    assign take       = completion && disc_reg == '0 && out_reg != '0;
    assign issue      = bus_stb_o && !bus_stall_i;
    assign push       = take && !pc_set && !rst_i;

    assign head      = q_mem[rd_ptr_reg];
    assign second    = q_mem[rd_ptr_reg + AW'(1)];
    assign is_long   = head[EXT_BIT];
    assign complete  = (occ_reg != '0) && (!is_long || occ_reg >= (AW+1)'(2));
    assign pop       = !stall_i && complete && !pc_set;

    always_comb begin
        pop_words = '0;
        if (pop) begin
            pop_words = is_long ? (AW+1)'(2) : (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_mem[wr_ptr_reg] <= {bus_err_i, bus_dat_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            occ_reg    <= '0;
            out_reg    <= '0;
            disc_reg   <= '0;
            adr_reg    <= RESET_PC;
            dpc_reg    <= RESET_PC;
            pc_reg     <= RESET_PC;
            ir_reg     <= '0;
            valid_reg  <= 1'b0;
            fault_reg  <= 1'b0;
        end else if (pc_set) begin
            // Everything still in flight becomes stale, less whatever lands now.
            disc_reg   <= disc_reg + DW'(out_reg) - DW'(drop || take);
            out_reg    <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            occ_reg    <= '0;
            adr_reg    <= pc_in;
            dpc_reg    <= pc_in;
            pc_reg     <= pc_in;
            ir_reg     <= '0;
            valid_reg  <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            out_reg <= out_reg + OW'(issue) - OW'(take);
            if (drop) begin
                disc_reg <= disc_reg - DW'(1);
            end
            if (issue) begin
                adr_reg <= adr_reg + 32'd4;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_reg + pop_words[AW-1:0];
            occ_reg    <= occ_reg + (AW+1)'(push) - pop_words;
            if (!stall_i) begin
                if (complete) begin
                    ir_reg    <= is_long ? {second[31:0], head[31:0]} : {32'h0, head[31:0]};
                    pc_reg    <= dpc_reg;
                    valid_reg <= 1'b1;
                    fault_reg <= head[32] || (is_long && second[32]);
                    dpc_reg   <= dpc_reg + (is_long ? 32'd8 : 32'd4);
                end else begin
                    ir_reg    <= '0;
                    valid_reg <= 1'b0;
                    fault_reg <= 1'b0;
                end
            end
        end
    end

    assign ir       = ir_reg;
    assign pc       = pc_reg;
    assign ir_valid = valid_reg;
    assign fault    = fault_reg;

endmodule

// File: tb/tb_ifetch_q.sv
// Randomized bench for ifetch_q: a pipelined slave with variable latency and stalls,
// and an instruction-stream model checking every cycle of ir/pc/bus outputs.
module tb_ifetch_q;

    localparam int          DEPTH    = 8;
    localparam int          MAX_OUT  = 4;
    localparam int          EXT_BIT  = 0;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bus_cyc_o, bus_stb_o;
    logic [31:0] bus_adr_o, bus_dat_i;
    logic        bus_ack_i, bus_err_i, bus_stall_i;
    logic        pc_set;
    logic [31:0] pc_in;
    logic        stall_i;
    logic [63:0] ir;
    logic [31:0] pc;
    logic        ir_valid, fault;

    ifetch_q #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC), .EXT_BIT(EXT_BIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_adr_o(bus_adr_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i),
        .bus_stall_i(bus_stall_i), .pc_set(pc_set), .pc_in(pc_in), .stall_i(stall_i),
        .ir(ir), .pc(pc), .ir_valid(ir_valid), .fault(fault)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;

    // Memory image and slave behaviour knobs.
    int          mode = 1;            // 0: mixed lengths, 1: all short, 2: directed 0/4 words
    logic [31:0] err_adr = 32'h1;     // unaligned value means no directed error word
    logic        err_rand_en = 1'b0;
    int          lat_min = 1, lat_max = 1, bstall_pct = 0;

    typedef struct {logic [31:0] adr; int unsigned due;} req_t;
    req_t        pend[$];
    int unsigned last_due = 0;

    // Instruction-stream model: fetch pointer, next expected pc, words in flight/queued.
    int          m_out = 0, m_disc = 0, m_occ = 0;
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] exp_pc = RESET_PC;

    logic [31:0] ret_pc[$];
    logic [63:0] ret_ir[$];
    logic        ret_fault[$];
    int unsigned ret_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1 + 32'h7F4A7C15;
        h = h ^ (h >> 15);
        if (mode == 2 && a == 32'h0) return 32'h0000_0001;
        if (mode == 2 && a == 32'h4) return 32'hDEAD_BEE0;
        if (mode != 0) h[EXT_BIT] = 1'b0;
        return h;
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return (a == err_adr) || (err_rand_en && a[6:2] == 5'd19);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive slave, check bus outputs, clock, update model, check ir/pc.
    task automatic step();
        logic        comp, acc, exp_stb, long_m, complete_m, pushed, exp_f;
        logic        was_rst, was_set, was_stall, p_v, p_f;
        logic [31:0] adr_s, h0, set_tgt, p_pc;
        logic [63:0] p_ir, exp_ir;
        int unsigned d;

        bus_stall_i = ($urandom_range(99) < bstall_pct);
        bus_ack_i   = 1'b0;
        bus_err_i   = 1'b0;
        bus_dat_i   = $urandom;
        if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            if (is_err(pend[0].adr)) bus_err_i = 1'b1;
            else                     bus_ack_i = 1'b1;
            bus_dat_i = mem_word(pend[0].adr);
            void'(pend.pop_front());
        end
        comp = bus_ack_i || bus_err_i;
        #1;
        exp_stb = !rst_i && !pc_set && (m_out < MAX_OUT) && (m_out + m_occ < DEPTH);
        check_eq("stb", bus_stb_o, exp_stb);
        check_eq("cyc", bus_cyc_o, !rst_i && (exp_stb || m_out != 0 || m_disc != 0));
        acc   = bus_stb_o && !bus_stall_i;
        adr_s = bus_adr_o;
        if (acc) check_eq("adr", adr_s, m_fetch);
        was_rst = rst_i; was_set = pc_set; was_stall = stall_i; set_tgt = pc_in;
        p_ir = ir; p_pc = pc; p_v = ir_valid; p_f = fault;
        h0         = mem_word(exp_pc);
        long_m     = h0[EXT_BIT];
        complete_m = (m_occ >= 1) && (!long_m || m_occ >= 2);

        @(posedge clk_i);
        cyc++;
        if (acc) begin
            d = cyc + $urandom_range(lat_max, lat_min);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{adr_s, d});
        end
        if (was_rst) begin
            m_out = 0; m_disc = 0; m_occ = 0; m_fetch = RESET_PC; exp_pc = RESET_PC;
        end else if (was_set) begin
            if (comp && (m_disc + m_out) > 0) m_disc = m_disc + m_out - 1;
            else                              m_disc = m_disc + m_out;
            m_out = 0; m_occ = 0; m_fetch = set_tgt; exp_pc = set_tgt;
        end else begin
            pushed = 1'b0;
            if (comp) begin
                if (m_disc > 0) m_disc--;
                else if (m_out > 0) begin m_out--; pushed = 1'b1; end
                else check_eq("orphan_ack", comp, 1'b0);
            end
            if (acc) begin m_out++; m_fetch = m_fetch + 32'd4; end
            m_occ = m_occ + int'(pushed);
            if (!was_stall && complete_m) m_occ = m_occ - (long_m ? 2 : 1);
        end

        @(negedge clk_i);
        if (was_rst || was_set) begin
            check_eq("redir_pc", pc, was_rst ? RESET_PC : set_tgt);
            check_eq("redir_adr", bus_adr_o, was_rst ? RESET_PC : set_tgt);
            check_eq("redir_ir", ir, 64'h0);
            check_eq("redir_valid", ir_valid, 1'b0);
            check_eq("redir_fault", fault, 1'b0);
        end else if (was_stall) begin
            check_eq("hold_ir", ir, p_ir);
            check_eq("hold_pc", pc, p_pc);
            check_eq("hold_valid", ir_valid, p_v);
            check_eq("hold_fault", fault, p_f);
        end else begin
            check_eq("valid", ir_valid, complete_m);
            if (complete_m) begin
                exp_ir = long_m ? {mem_word(exp_pc + 32'd4), h0} : {32'h0, h0};
                exp_f  = is_err(exp_pc) || (long_m && is_err(exp_pc + 32'd4));
                check_eq("pc", pc, exp_pc);
                check_eq("ir", ir, exp_ir);
                check_eq("fault", fault, exp_f);
                ret_pc.push_back(pc); ret_ir.push_back(ir);
                ret_fault.push_back(fault); ret_cyc.push_back(cyc);
                $display("retire cyc=%0d pc=%08h ir=%016h fault=%0b", cyc, pc, ir, fault);
                exp_pc = exp_pc + (long_m ? 32'd8 : 32'd4);
            end else begin
                check_eq("bubble_ir", ir, 64'h0);
                check_eq("bubble_fault", fault, 1'b0);
                check_eq("bubble_pc", pc, p_pc);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold reset until the slave has answered everything it accepted.
    task automatic do_reset();
        rst_i = 1'b1; pc_set = 1'b0; stall_i = 1'b0;
        run(2);
        for (int i = 0; i < 50 && pend.size() > 0; i++) step();
        check_eq("reset_drain_bound", pend.size(), 0);
        rst_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        rst_i = 1'b1; pc_set = 1'b0; pc_in = '0; stall_i = 1'b0;
        bus_dat_i = '0; bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_stall_i = 1'b0;
        @(negedge clk_i);

        // Zero-wait slave, short words: one instruction per cycle from RESET_PC.
        mode = 1; lat_min = 1; lat_max = 1; bstall_pct = 0;
        do_reset();
        n0 = ret_pc.size();
        run(12);
        check_eq("r040_count", ret_pc.size() >= n0 + 4, 1'b1);
        if (ret_pc.size() >= n0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq("r040_pc", ret_pc[n0+i], 64'(4 * i));
                check_eq("r040_b2b", ret_cyc[n0+i] - ret_cyc[n0], 64'(i));
            end
        end

        // Two-word instruction at 0.
        mode = 2;
        do_reset();
        n0 = ret_pc.size();
        run(10);
        check_eq("r041_count", ret_pc.size() >= n0 + 2, 1'b1);
        if (ret_pc.size() >= n0 + 2) begin
            check_eq("r041_ir", ret_ir[n0], 64'hDEADBEE0_00000001);
            check_eq("r041_pc0", ret_pc[n0], 64'h0);
            check_eq("r041_pc1", ret_pc[n0+1], 64'h8);
        end

        // Downstream stall fills the queue; release drains it contiguously.
        mode = 1;
        do_reset();
        run(3);
        stall_i = 1'b1;
        run(20);
        check_eq("r042_full_stb", bus_stb_o, 1'b0);
        check_eq("r042_full_cyc", bus_cyc_o, 1'b0);
        stall_i = 1'b0;
        n0 = ret_pc.size();
        run(20);
        check_eq("r042_count", ret_pc.size() >= n0 + 12, 1'b1);
        if (ret_pc.size() >= n0 + 12) begin
            for (int i = 0; i < 11; i++)
                check_eq("r042_contig", ret_pc[n0+i+1], ret_pc[n0+i] + 32'd4);
        end

        // Redirect with three requests outstanding on a 3-cycle slave.
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 20 && m_out != 3; i++) step();
        check_eq("r043_out_bound", m_out, 3);
        pc_set = 1'b1; pc_in = 32'h100;
        step();
        pc_set = 1'b0;
        n0 = ret_pc.size();
        run(20);
        check_eq("r043_count", ret_pc.size() > n0, 1'b1);
        if (ret_pc.size() > n0) begin
            check_eq("r043_pc", ret_pc[n0], 64'h100);
            check_eq("r043_ir", ret_ir[n0], {32'h0, mem_word(32'h100)});
        end

        // Bus error on the word at 0x8.
        lat_min = 1; lat_max = 1; err_adr = 32'h8;
        do_reset();
        n0 = ret_pc.size();
        run(12);
        check_eq("r044_count", ret_pc.size() >= n0 + 4, 1'b1);
        if (ret_pc.size() >= n0 + 4) begin
            check_eq("r044_f4", ret_fault[n0+1], 1'b0);
            check_eq("r044_f8", ret_fault[n0+2], 1'b1);
            check_eq("r044_f12", ret_fault[n0+3], 1'b0);
        end
        err_adr = 32'h1;

        // Reset with requests in flight; their acks land while reset is held.
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 20 && m_out < 2; i++) step();
        check_eq("r045_out_bound", m_out >= 2, 1'b1);
        rst_i = 1'b1;
        step();
        check_eq("r045_valid", ir_valid, 1'b0);
        check_eq("r045_pc", pc, RESET_PC);
        do_reset();
        n0 = ret_pc.size();
        run(12);
        check_eq("r045_count", ret_pc.size() > n0, 1'b1);
        if (ret_pc.size() > n0) check_eq("r045_first_pc", ret_pc[n0], RESET_PC);

        // Random traffic: mixed lengths, slave stalls/latency, errors, redirects.
        mode = 0; err_rand_en = 1'b1; lat_min = 1; lat_max = 4; bstall_pct = 25;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            stall_i = ($urandom_range(99) < 30);
            pc_set  = pc_set ? ($urandom_range(99) < 40) : ($urandom_range(99) < 2);
            if (pc_set)
                pc_in = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0
                                                 : {22'h0, 8'($urandom_range(255)), 2'b00};
            step();
        end
        pc_set = 1'b0; stall_i = 1'b0;
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_q.md
IFETCH_Q -- requirements
Module: ifetch_q

Interface
REQ-001 Parameter DEPTH, 8, prefetch queue depth in 32-bit words; power of two, 4..64.
REQ-002 Parameter MAX_OUT, 4, maximum outstanding bus requests; 1..DEPTH.
REQ-003 Parameter RESET_PC, 32'h0, fetch and decode address after reset.
REQ-004 Parameter EXT_BIT, 0, bit index in the first word that marks a two-word (64-bit) instruction.
REQ-005 clk_i  in  1  clock; single clock domain, all state on rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 bus_cyc_o  out  1  Wishbone pipelined cycle.
REQ-008 bus_stb_o  out  1  request strobe.
REQ-009 bus_adr_o  out  32  request word address, byte-addressed, 4-aligned.
REQ-010 bus_dat_i  in  32  read data.
REQ-011 bus_ack_i  in  1  read data valid.
REQ-012 bus_err_i  in  1  bus error, completes a request in place of ack.
REQ-013 bus_stall_i  in  1  slave cannot accept a request this cycle.
REQ-014 pc_set  in  1  redirect fetch to pc_in.
REQ-015 pc_in  in  32  redirect target, 4-aligned.
REQ-016 stall_i  in  1  downstream holds the current ir.
REQ-017 ir  out  64  instruction; {32'h0,w0} short, {w1,w0} long.
REQ-018 pc  out  32  address of the instruction in ir.
REQ-019 ir_valid  out  1  ir holds a real instruction.
REQ-020 fault  out  1  the instruction in ir contains a word returned with bus_err_i.

Function
REQ-021 Request issued when bus_stb_o && !bus_stall_i; bus_adr_o then advances by 4 on the next cycle.
REQ-022 bus_stb_o = !rst_i && !pc_set && (outstanding < MAX_OUT) && (outstanding + occupancy < DEPTH); the queue never overflows.
REQ-023 bus_cyc_o = bus_stb_o || outstanding != 0 || discard != 0.
REQ-024 Completion: ack or err decrements outstanding; if discard != 0, the completion decrements discard and is dropped; otherwise {err, dat} is pushed into the queue.
REQ-025 outstanding is updated in the same cycle for a simultaneous issue and completion: net change 0.
REQ-026 Decode: the head word is short if bit EXT_BIT is 0 and needs occupancy >= 1; it is long if bit EXT_BIT is 1 and needs occupancy >= 2.
REQ-027 Output update when !stall_i and the head instruction is complete: pop 1 or 2 words, ir <= instruction, pc <= dpc, ir_valid <= 1, fault <= OR of popped err flags, dpc += 4 or 8.
REQ-028 When !stall_i and the head instruction is incomplete: ir <= 0, ir_valid <= 0, fault <= 0; pc, dpc and the queue are held; a lone long first word stays queued.
REQ-029 When stall_i && !pc_set: ir, pc, ir_valid, fault and the queue are all held.
REQ-030 pc_set, priority over all other activity: queue flushed; bus_adr_o <= pc_in; dpc <= pc_in; pc <= pc_in; ir <= 0; ir_valid <= 0; fault <= 0; no request that cycle.
REQ-031 On pc_set: discard <= discard + outstanding - (completion this cycle); outstanding <= 0.
REQ-032 Back-to-back pc_set: each pc_set overrides the prior target; discard accumulates correctly.
REQ-033 A completion with discard == 0 and outstanding == 0 is ignored; the verification bench flags it as a protocol error.
REQ-034 Queue pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is log2(DEPTH)+1 bits.
REQ-035 Address arithmetic is 32-bit and wraps from 32'hFFFFFFFC to 32'h0 without special handling.

Reset
REQ-036 When rst_i is high at a clock edge: pc = RESET_PC, dpc = RESET_PC, bus_adr_o = RESET_PC, ir = 0, ir_valid = 0, fault = 0, queue empty, outstanding = 0, discard = 0.
REQ-037 bus_cyc_o and bus_stb_o are 0 combinationally while rst_i is high.
REQ-038 Reset mid-transaction abandons all in-flight requests; acks arriving after reset are ignored per REQ-033, with no push.
REQ-039 The first request is issued in the first cycle after rst_i deasserts.

Verification
REQ-040 Zero-wait slave, short words, RESET_PC=0: first ir_valid=1 with pc=0, then pc=4, 8, 12 on consecutive cycles.
REQ-041 Words 0x00000001 and 0xDEADBEE0 at 0/4 (EXT_BIT=0): ir=64'hDEADBEE0_00000001, pc=0; next instruction has pc=8.
REQ-042 stall_i held 20 cycles with a zero-wait slave: queue fills to DEPTH; bus_stb_o=0 while full; no push is lost; release yields contiguous pcs.
REQ-043 Slave with 3-cycle ack latency, MAX_OUT=4; pc_set to 0x100 with 3 requests outstanding: 3 stale acks dropped; first ir_valid shows pc=0x100 with data from 0x100.
REQ-044 bus_err_i on the word at 0x8: the instruction at pc=8 has fault=1; neighbouring instructions have fault=0.
REQ-045 rst_i asserted with 2 requests outstanding: all outputs at reset values next cycle; late acks leave the queue empty.
